// File: rtl/video_stream_gen.sv
// Programmable-resolution video timing generator plus a frame-locked AXI4-Stream
// test-pattern source (solid, colour bars, checker, scrolling bars) on one pixel clock.
module video_stream_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int CHECK_LOG2 = 5,
    parameter int CNT_W      = 12
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [CNT_W-1:0]     pixel_x,
    output logic [CNT_W-1:0]     pixel_y,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 hblank,
    output logic                 vblank,
    output logic                 video_on,
    output logic                 frame_start,
    output logic [3*COLOR_W-1:0] tdata,
    output logic                 tvalid,
    output logic                 tuser,
    output logic                 tlast,
    input  logic                 tready,
    output logic                 frame_late,
    output logic [7:0]           frame_count,
    output logic                 dbg_streaming
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] SX_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] SY_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_e;

    // h_q/v_q hold the position the registered outputs will show one cycle later.
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, hblank_q, hblank_d, vblank_q, vblank_d;
    logic video_on_q, video_on_d, frame_start_q, frame_start_d;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] sx_q, sx_d, sy_q, sy_d, bcnt_q, bcnt_d;
    logic [2:0]       bar_q, bar_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       fc_lat_q, fc_lat_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic [3*COLOR_W-1:0] tdata_q, tdata_d;
    logic tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d, frame_late_q, frame_late_d;

    logic             xfer, load, step;
    logic [CNT_W-1:0] nsx, nsy, nbcnt;
    logic [2:0]       nbar, pbar;
    logic [3*COLOR_W-1:0] bar_rgb, pix;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_END) begin
            h_d = '0;
            v_d = (v_q == V_END) ? '0 : v_q + 1'b1;
        end
        pixel_x_d     = h_q;
        pixel_y_d     = v_q;
        hblank_d      = (h_q >= H_ACT);
        vblank_d      = (v_q >= V_ACT);
        video_on_d    = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_d       = (h_q >= HS_FIRST && h_q <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (v_q >= VS_FIRST && v_q <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
        frame_start_d = (h_q == '0) && (v_q == '0);
    end

    // Handshake: a beat moves when tvalid && tready; while stalled the beat and
    // tvalid are held unchanged, and tvalid drops only after a frame's last beat.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        bcnt_d        = bcnt_q;
        bar_d         = bar_q;
        mode_d        = mode_q;
        fc_lat_d      = fc_lat_q;
        frame_count_d = frame_count_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tuser_d       = tuser_q;
        tlast_d       = tlast_q;
        load          = 1'b0;
        step          = 1'b0;
        nsx           = sx_q;
        nsy           = sy_q;
        nbcnt         = bcnt_q;
        nbar          = bar_q;
        xfer          = tvalid_q & tready;
        case (state_q)
            S_IDLE: begin
                if (frame_start_q && enable) begin
                    state_d  = S_STREAM;
                    load     = 1'b1;
                    mode_d   = mode;
                    fc_lat_d = frame_count_q[2:0];
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    if (sx_q == SX_LAST && sy_q == SY_LAST) begin
                        frame_count_d = frame_count_q + 8'd1;
                        pending_d     = 1'b0;
                        if (pending_q && enable) begin
                            load     = 1'b1;
                            mode_d   = mode;
                            fc_lat_d = frame_count_d[2:0];
                        end else begin
                            state_d  = S_IDLE;
                            tvalid_d = 1'b0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        step = 1'b1;
                        if (sx_q == SX_LAST) begin
                            nsx   = '0;
                            nsy   = sy_q + 1'b1;
                            nbcnt = '0;
                            nbar  = '0;
                        end else begin
                            nsx = sx_q + 1'b1;
                            if (bcnt_q == BAR_LAST) begin
                                nbcnt = '0;
                                nbar  = bar_q + 3'd1;
                            end else begin
                                nbcnt = bcnt_q + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            nsx   = '0;
            nsy   = '0;
            nbcnt = '0;
            nbar  = '0;
        end

        pbar    = (mode_d == 2'd3) ? nbar + fc_lat_d : nbar;
        bar_rgb = {{COLOR_W{~pbar[1]}}, {COLOR_W{~pbar[2]}}, {COLOR_W{~pbar[0]}}};
        case (mode_d)
            2'd0:    pix = solid_rgb;
            2'd2:    pix = {(3*COLOR_W){nsx[CHECK_LOG2] ^ nsy[CHECK_LOG2]}};
            default: pix = bar_rgb;
        endcase

        if (load || step) begin
            sx_d     = nsx;
            sy_d     = nsy;
            bcnt_d   = nbcnt;
            bar_d    = nbar;
            tvalid_d = 1'b1;
            tuser_d  = (nsx == '0) && (nsy == '0);
            tlast_d  = (nsx == SX_LAST);
            tdata_d  = pix;
        end
        // A frame_start that lands while a frame is still streaming queues one more frame.
        frame_late_d = frame_start_d && (state_d == S_STREAM);
        if (frame_late_d) pending_d = 1'b1;
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            h_q <= '0;  v_q <= '0;
            pixel_x_q <= '0;  pixel_y_q <= '0;
            hsync_q <= ~HSYNC_POL;  vsync_q <= ~VSYNC_POL;
            hblank_q <= 1'b0;  vblank_q <= 1'b0;
            video_on_q <= 1'b0;  frame_start_q <= 1'b0;
            state_q <= S_IDLE;  pending_q <= 1'b0;
            sx_q <= '0;  sy_q <= '0;  bcnt_q <= '0;  bar_q <= '0;
            mode_q <= '0;  fc_lat_q <= '0;  frame_count_q <= '0;
            tdata_q <= '0;  tvalid_q <= 1'b0;  tuser_q <= 1'b0;  tlast_q <= 1'b0;
            frame_late_q <= 1'b0;
        end else begin
            h_q <= h_d;  v_q <= v_d;
            pixel_x_q <= pixel_x_d;  pixel_y_q <= pixel_y_d;
            hsync_q <= hsync_d;  vsync_q <= vsync_d;
            hblank_q <= hblank_d;  vblank_q <= vblank_d;
            video_on_q <= video_on_d;  frame_start_q <= frame_start_d;
            state_q <= state_d;  pending_q <= pending_d;
            sx_q <= sx_d;  sy_q <= sy_d;  bcnt_q <= bcnt_d;  bar_q <= bar_d;
            mode_q <= mode_d;  fc_lat_q <= fc_lat_d;  frame_count_q <= frame_count_d;
            tdata_q <= tdata_d;  tvalid_q <= tvalid_d;  tuser_q <= tuser_d;  tlast_q <= tlast_d;
            frame_late_q <= frame_late_d;
        end
    end

    assign pixel_x       = pixel_x_q;
    assign pixel_y       = pixel_y_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign hblank        = hblank_q;
    assign vblank        = vblank_q;
    assign video_on      = video_on_q;
    assign frame_start   = frame_start_q;
    assign tdata         = tdata_q;
    assign tvalid        = tvalid_q;
    assign tuser         = tuser_q;
    assign tlast         = tlast_q;
    assign frame_late    = frame_late_q;
    assign frame_count   = frame_count_q;
    assign dbg_streaming = (state_q == S_STREAM);
endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen on a tiny 14x7 raster with a
// cycle-count timing model and a per-frame expected-beat queue.
module tb_video_stream_gen;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BAR = HA / 8;
    localparam int NBEATS = HA * VA;

    logic        pixel_clk = 1'b0;
    logic        reset, enable, tready;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;
    logic [11:0] pixel_x, pixel_y;
    logic        hsync, vsync, hblank, vblank, video_on, frame_start;
    logic [11:0] tdata;
    logic        tvalid, tuser, tlast, frame_late, dbg_streaming;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;
    int exp_pos;
    logic [13:0] exp_q[$];
    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    video_stream_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .COLOR_W(4), .CHECK_LOG2(1), .CNT_W(12)
    ) dut (
        .pixel_clk(pixel_clk), .reset(reset), .enable(enable), .mode(mode),
        .solid_rgb(solid_rgb), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .video_on(video_on), .frame_start(frame_start), .tdata(tdata),
        .tvalid(tvalid), .tuser(tuser), .tlast(tlast), .tready(tready),
        .frame_late(frame_late), .frame_count(frame_count),
        .dbg_streaming(dbg_streaming)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Raster position shown in the current cycle: 0 on the first cycle after reset release.
    always @(posedge pixel_clk or posedge reset) begin
        if (reset) exp_pos <= -1;
        else       exp_pos <= (exp_pos + 1) % FRAME;
    end

    function automatic logic [11:0] pix(input int m, input int x, input int y, input int fc);
        case (m)
            0:       return solid_rgb;
            1:       return bar_tab[(x / BAR) % 8];
            2:       return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: return bar_tab[(x / BAR + fc) % 8];
        endcase
    endfunction

    task automatic push_frame(input int m, input int fc);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                exp_q.push_back({pix(m, x, y, fc), 1'(x == 0 && y == 0), 1'(x == HA - 1)});
    endtask

    task automatic wait_fs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge pixel_clk);
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(negedge pixel_clk);
        checks++;
        if ({pixel_x, pixel_y} !== 24'h0) begin
            errors++; $display("FAIL reset_xy: got %h/%h want 0/0", pixel_x, pixel_y);
        end
        checks++;
        if ({hsync, vsync} !== 2'b11) begin
            errors++; $display("FAIL reset_sync: got %b%b want 11", hsync, vsync);
        end
        checks++;
        if ({hblank, vblank, video_on, frame_start} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b%b%b%b want 0000", hblank, vblank, video_on, frame_start);
        end
        checks++;
        if ({tvalid, tuser, tlast, frame_late} !== 4'b0 || tdata !== 12'h0) begin
            errors++; $display("FAIL reset_stream: got v%b u%b l%b late%b d%h want all 0", tvalid, tuser, tlast, frame_late, tdata);
        end
        checks++;
        if (frame_count !== 8'd0 || dbg_streaming !== 1'b0) begin
            errors++; $display("FAIL reset_fc: got fc%0d st%b want 0/0", frame_count, dbg_streaming);
        end
    endtask

    task automatic test_timing_enable_off;
        int h, v, fs_cnt, von_cnt;
        logic [29:0] exp_vec;
        fs_cnt = 0; von_cnt = 0;
        reset = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge pixel_clk);
            h = exp_pos % HT;
            v = exp_pos / HT;
            exp_vec = {12'(h), 12'(v),
                       !(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
                       h >= HA, v >= VA, (h < HA) && (v < VA), (h == 0) && (v == 0)};
            checks++;
            if ({pixel_x, pixel_y, hsync, vsync, hblank, vblank, video_on, frame_start} !== exp_vec) begin
                errors++; $display("FAIL timing cycle %0d: got %h want %h", i,
                    {pixel_x, pixel_y, hsync, vsync, hblank, vblank, video_on, frame_start}, exp_vec);
            end
            checks++;
            if (tvalid !== 1'b0) begin
                errors++; $display("FAIL enable_off cycle %0d: tvalid got %b want 0", i, tvalid);
            end
            fs_cnt += int'(frame_start);
            von_cnt += int'(video_on);
        end
        checks++;
        if (fs_cnt != 2 || von_cnt != 2 * HA * VA) begin
            errors++; $display("FAIL timing_counts: frame_start %0d want 2, video_on %0d want %0d", fs_cnt, von_cnt, 2 * HA * VA);
        end
    endtask

    task automatic test_bars;
        bit ok;
        logic [13:0] e;
        mode = 2'd1; enable = 1'b1; tready = 1'b1;
        wait_fs(2 * FRAME, ok);
        checks++;
        if (!ok || tvalid !== 1'b0) begin
            errors++; $display("FAIL bars_start: found %b tvalid %b want 1/0", ok, tvalid);
        end
        push_frame(1, exp_fc);
        for (int b = 0; b < NBEATS; b++) begin
            @(negedge pixel_clk);
            e = exp_q.pop_front();
            checks++;
            if (tvalid !== 1'b1 || {tdata, tuser, tlast} !== e) begin
                errors++; $display("FAIL bars_beat %0d: got v%b %h want v1 %h", b, tvalid, {tdata, tuser, tlast}, e);
            end
        end
        exp_fc++;
        @(negedge pixel_clk);
        checks++;
        if (tvalid !== 1'b0 || frame_count !== 8'(exp_fc)) begin
            errors++; $display("FAIL bars_end: got v%b fc%0d want v0 fc%0d", tvalid, frame_count, exp_fc);
        end
        enable = 1'b0;
    endtask

    task automatic test_random_ready;
        bit ok, saw_fs, prev_stall;
        logic [13:0] prev_beat, e;
        int m;
        for (int f = 0; f < 3; f++) begin
            m = $urandom_range(0, 3);
            mode = 2'(m); solid_rgb = 12'($urandom_range(0, 4095));
            enable = 1'b1; tready = 1'b0;
            wait_fs(2 * FRAME, ok);
            checks++;
            if (!ok || frame_late !== 1'b0) begin
                errors++; $display("FAIL rand_start f%0d: found %b late %b want 1/0", f, ok, frame_late);
            end
            push_frame(m, exp_fc);
            saw_fs = 1'b0; prev_stall = 1'b0; prev_beat = '0;
            for (int c = 1; c < FRAME - 2 && exp_q.size() > 0; c++) begin
                @(negedge pixel_clk);
                if (frame_start === 1'b1) saw_fs = 1'b1;
                checks++;
                if (frame_late !== 1'b0) begin
                    errors++; $display("FAIL rand_late f%0d c%0d: got %b want 0", f, c, frame_late);
                end
                if (prev_stall) begin
                    checks++;
                    if (tvalid !== 1'b1 || {tdata, tuser, tlast} !== prev_beat) begin
                        errors++; $display("FAIL rand_stall f%0d c%0d: got v%b %h want v1 %h", f, c, tvalid, {tdata, tuser, tlast}, prev_beat);
                    end
                end
                if (tvalid === 1'b1) begin
                    if (exp_q.size() + 2 >= FRAME - 1 - c) tready = 1'b1;
                    else tready = 1'($urandom_range(0, 1));
                    if (tready) begin
                        e = exp_q.pop_front();
                        checks++;
                        if ({tdata, tuser, tlast} !== e) begin
                            errors++; $display("FAIL rand_beat f%0d c%0d mode %0d: got %h want %h", f, c, m, {tdata, tuser, tlast}, e);
                        end
                    end
                    prev_stall = !tready;
                    prev_beat = {tdata, tuser, tlast};
                end else begin
                    tready = 1'($urandom_range(0, 1));
                    prev_stall = 1'b0;
                end
            end
            checks++;
            if (exp_q.size() != 0 || saw_fs) begin
                errors++; $display("FAIL rand_complete f%0d: left %0d beats, saw frame_start %b want 0/0", f, exp_q.size(), saw_fs);
            end
            exp_q.delete();
            exp_fc++;
            @(negedge pixel_clk);
            checks++;
            if (tvalid !== 1'b0 || frame_count !== 8'(exp_fc)) begin
                errors++; $display("FAIL rand_end f%0d: got v%b fc%0d want v0 fc%0d", f, tvalid, frame_count, exp_fc);
            end
            enable = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int nb;
        logic [13:0] e;
        mode = 2'd3; enable = 1'b1; tready = 1'b0;
        wait_fs(2 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_start: frame_start found %b want 1", ok);
        end
        push_frame(3, exp_fc);
        for (int c = 1; c <= 100; c++) begin
            @(negedge pixel_clk);
            tready = 1'b0;
            checks++;
            if (tvalid !== 1'b1 || {tdata, tuser, tlast} !== exp_q[0]) begin
                errors++; $display("FAIL bp_hold c%0d: got v%b %h want v1 %h", c, tvalid, {tdata, tuser, tlast}, exp_q[0]);
            end
            checks++;
            if (c == FRAME) begin
                if (frame_start !== 1'b1 || frame_late !== 1'b1) begin
                    errors++; $display("FAIL bp_late: got fs%b late%b want 1/1", frame_start, frame_late);
                end
                push_frame(3, exp_fc + 1);
            end else if (frame_late !== 1'b0) begin
                errors++; $display("FAIL bp_nolate c%0d: got %b want 0", c, frame_late);
            end
        end
        nb = 0;
        for (int c = 0; c < 2 * NBEATS + 8 && exp_q.size() > 0; c++) begin
            @(negedge pixel_clk);
            tready = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if (tvalid !== 1'b1 || {tdata, tuser, tlast} !== e) begin
                errors++; $display("FAIL bp_drain beat %0d: got v%b %h want v1 %h", nb, tvalid, {tdata, tuser, tlast}, e);
            end
            nb++;
            if (nb % NBEATS == 0) exp_fc++;
            if (nb == NBEATS + 1) enable = 1'b0;
        end
        @(negedge pixel_clk);
        checks++;
        if (tvalid !== 1'b0 || frame_count !== 8'(exp_fc)) begin
            errors++; $display("FAIL bp_end: got v%b fc%0d want v0 fc%0d", tvalid, frame_count, exp_fc);
        end
    endtask

    task automatic test_mid_reset;
        bit ok;
        logic [13:0] e;
        mode = 2'd2; enable = 1'b1; tready = 1'b1;
        wait_fs(2 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mr_start: frame_start found %b want 1", ok);
        end
        push_frame(2, exp_fc);
        for (int c = 1; c <= 6; c++) begin
            @(negedge pixel_clk);
            e = exp_q.pop_front();
            checks++;
            if (tvalid !== 1'b1 || {tdata, tuser, tlast} !== e) begin
                errors++; $display("FAIL mr_beat %0d: got v%b %h want v1 %h", c - 1, tvalid, {tdata, tuser, tlast}, e);
            end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({tvalid, tuser, tlast, frame_late} !== 4'b0 || tdata !== 12'h0 || frame_count !== 8'd0) begin
            errors++; $display("FAIL mr_async_stream: got v%b u%b l%b d%h fc%0d want 0", tvalid, tuser, tlast, tdata, frame_count);
        end
        checks++;
        if ({pixel_x, pixel_y} !== 24'h0 || hsync !== 1'b1 || video_on !== 1'b0) begin
            errors++; $display("FAIL mr_async_timing: got x%0d y%0d hs%b von%b want 0 0 1 0", pixel_x, pixel_y, hsync, video_on);
        end
        exp_q.delete();
        exp_fc = 0;
        repeat (2) @(negedge pixel_clk);
        reset = 1'b0;
        @(negedge pixel_clk);
        checks++;
        if (frame_start !== 1'b1 || video_on !== 1'b1 || tvalid !== 1'b0) begin
            errors++; $display("FAIL mr_first_cycle: got fs%b von%b v%b want 1 1 0", frame_start, video_on, tvalid);
        end
        push_frame(2, exp_fc);
        for (int b = 0; b < NBEATS; b++) begin
            @(negedge pixel_clk);
            e = exp_q.pop_front();
            checks++;
            if (tvalid !== 1'b1 || {tdata, tuser, tlast} !== e) begin
                errors++; $display("FAIL mr_restart beat %0d: got v%b %h want v1 %h", b, tvalid, {tdata, tuser, tlast}, e);
            end
        end
        exp_fc++;
        @(negedge pixel_clk);
        checks++;
        if (tvalid !== 1'b0 || frame_count !== 8'(exp_fc)) begin
            errors++; $display("FAIL mr_end: got v%b fc%0d want v0 fc%0d", tvalid, frame_count, exp_fc);
        end
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; tready = 1'b0; mode = 2'd0; solid_rgb = 12'h000;
        repeat (3) @(negedge pixel_clk);
        test_reset;
        test_timing_enable_off;
        test_bars;
        test_random_ready;
        test_backpressure;
        test_mid_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
